// File: rtl/qkd_sched_pkg.sv
// Shared definitions for the QKD channel scheduler: FSM states, demux select codes
// and the select-to-pulse decode.
package qkd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PULSE = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Pulse drive is always the one-hot image of the select, so the two can never disagree.
    function automatic logic [1:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            SEL_CH0: return 2'b01;
            SEL_CH1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-state down-counter: loaded with a state length on every state change,
// flags the last cycle of that state.
module slot_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/qkd_channel_scheduler.sv
// Slot scheduler for the Alice 1-to-2 demux: one random bit per PERIOD-cycle slot,
// a PULSE_W-wide one-hot drive on the chosen channel, then a guard gap.
module qkd_channel_scheduler
    import qkd_sched_pkg::*;
#(
    parameter int PERIOD  = 16,
    parameter int PULSE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    output logic [1:0]       sel_out,
    output logic [1:0]       pulse_out,
    output logic             slot_start,
    output logic             busy,
    output logic             underflow,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int TW = $clog2(PERIOD + 1);
    localparam logic [TW-1:0] LEN_FETCH = TW'(1);
    localparam logic [TW-1:0] LEN_PULSE = TW'(PULSE_W);
    localparam logic [TW-1:0] LEN_GUARD = TW'(PERIOD - 1 - PULSE_W);

    if (PERIOD < 4 || PULSE_W < 1 || PULSE_W > PERIOD - 2) begin : g_param_check
        $error("qkd_channel_scheduler: need PERIOD>=4 and 1<=PULSE_W<=PERIOD-2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t        state, state_nxt;
    logic [1:0]    sel_nxt;
    logic [TW-1:0] len_nxt;
    logic          tmr_load, tmr_done;
    logic          fetch, take, miss;

    assign fetch      = (state == ST_FETCH);
    assign bit_ready  = fetch;
    assign slot_start = fetch;
    assign take       = fetch & bit_valid;
    assign miss       = fetch & ~bit_valid;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_out;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_FETCH;
            ST_FETCH: begin
                state_nxt = ST_PULSE;
                if (bit_valid) sel_nxt = {1'b0, bit_data};
            end
            ST_PULSE: if (tmr_done) begin
                state_nxt = ST_GUARD;
                sel_nxt   = SEL_NONE;
            end
            ST_GUARD: if (tmr_done) state_nxt = en ? ST_FETCH : ST_IDLE;
        endcase

        case (state_nxt)
            ST_PULSE: len_nxt = LEN_PULSE;
            ST_GUARD: len_nxt = LEN_GUARD;
            default:  len_nxt = LEN_FETCH;
        endcase
        tmr_load = (state_nxt != state);
    end

    slot_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (len_nxt),
        .done (tmr_done)
    );

    // Every state change is also a timer reload, so each state lasts exactly its length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_out   <= SEL_NONE;
            pulse_out <= 2'b00;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_out   <= sel_nxt;
            pulse_out <= sel_onehot(sel_nxt);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // clr wins over a same-cycle count, but a same-cycle miss still leaves underflow set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt  <= '0;
            miss_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            if (clr)       sent_cnt <= '0;
            else if (take) sent_cnt <= sat_inc(sent_cnt);

            if (clr)       miss_cnt <= '0;
            else if (miss) miss_cnt <= sat_inc(miss_cnt);

            if (miss)      underflow <= 1'b1;
            else if (clr)  underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qkd_channel_scheduler.sv
// Self-checking bench for qkd_channel_scheduler (PERIOD=8, PULSE_W=3, CNT_W=4) against a
// slot-position reference model.
module tb_qkd_channel_scheduler;

    localparam int PERIOD  = 8;
    localparam int PULSE_W = 3;
    localparam int CNT_W   = 4;
    localparam int VW      = 8 + 2 * CNT_W;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_data = 1'b0;
    logic             bit_ready;
    logic [1:0]       sel_out;
    logic [1:0]       pulse_out;
    logic             slot_start;
    logic             busy;
    logic             underflow;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int checks = 0;
    int fails  = 0;

    qkd_channel_scheduler #(.PERIOD(PERIOD), .PULSE_W(PULSE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .sel_out    (sel_out),
        .pulse_out  (pulse_out),
        .slot_start (slot_start),
        .busy       (busy),
        .underflow  (underflow),
        .sent_cnt   (sent_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] dut_v;
    assign dut_v = {bit_ready, sel_out, pulse_out, slot_start, busy, underflow, sent_cnt, miss_cnt};

    // Reference model: m_pos is the cycle index within the current slot, -1 when idle.
    int   m_pos  = -1;
    int   m_sent = 0;
    int   m_miss = 0;
    logic m_uf   = 1'b0;
    logic m_has  = 1'b0;
    logic m_bit  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos  <= -1;
            m_sent <= 0;
            m_miss <= 0;
            m_uf   <= 1'b0;
            m_has  <= 1'b0;
            m_bit  <= 1'b0;
        end else begin
            if (clr)                          m_sent <= 0;
            else if (m_pos == 0 && bit_valid) m_sent <= (m_sent == CMAX) ? CMAX : m_sent + 1;
            if (clr)                           m_miss <= 0;
            else if (m_pos == 0 && !bit_valid) m_miss <= (m_miss == CMAX) ? CMAX : m_miss + 1;
            if (m_pos == 0 && !bit_valid) m_uf <= 1'b1;
            else if (clr)                 m_uf <= 1'b0;
            if (m_pos == 0) begin
                m_has <= bit_valid;
                m_bit <= bit_data;
            end
            if (m_pos < 0 || m_pos == PERIOD - 1) m_pos <= en ? 0 : -1;
            else                                  m_pos <= m_pos + 1;
        end
    end

    function automatic logic [VW-1:0] exp_v();
        logic       on;
        logic [1:0] s, p;
        on = (m_pos >= 1) && (m_pos <= PULSE_W) && m_has;
        s  = on ? {1'b0, m_bit} : 2'b11;
        p  = on ? (m_bit ? 2'b10 : 2'b01) : 2'b00;
        return {(m_pos == 0), s, p, (m_pos == 0), (m_pos >= 0), m_uf,
                CNT_W'(m_sent), CNT_W'(m_miss)};
    endfunction

    task automatic goto_fetch(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 2 * PERIOD; g++) begin
            if (m_pos == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] rv;
        rst = 1'b1; en = 1'b0; clr = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        repeat (3) @(negedge clk);
        rv = {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
        checks++;
        if (dut_v !== rv) begin
            fails++; $display("FAIL reset_values got=%h exp=%h", dut_v, rv);
        end
        checks++;
        if (dut_v !== exp_v()) begin
            fails++; $display("FAIL reset_model got=%h exp=%h", dut_v, exp_v());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic       bits [0:2];
        logic [1:0] sels [$];
        logic [1:0] prev;
        logic [5:0] seq;
        int idx, starts, w01, w10;
        bits = '{1'b0, 1'b1, 1'b1};
        idx = 0; starts = 0; w01 = 0; w10 = 0; prev = 2'b00;
        en = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3 * PERIOD; i++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL basic_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (slot_start) starts++;
            if (pulse_out == 2'b01) w01++;
            if (pulse_out == 2'b10) w10++;
            if (pulse_out != 2'b00 && prev == 2'b00) sels.push_back(sel_out);
            prev = pulse_out;
            if (m_pos == 0 && idx < 3) begin
                bit_data = bits[idx];
                idx++;
            end
            @(negedge clk);
        end
        seq = (sels.size() == 3) ? {sels[0], sels[1], sels[2]} : 6'h3f;
        checks++;
        if (starts != 3) begin fails++; $display("FAIL basic_starts got=%0d exp=3", starts); end
        checks++;
        if (w01 != PULSE_W) begin fails++; $display("FAIL basic_ch0_width got=%0d exp=%0d", w01, PULSE_W); end
        checks++;
        if (w10 != 2 * PULSE_W) begin fails++; $display("FAIL basic_ch1_width got=%0d exp=%0d", w10, 2 * PULSE_W); end
        checks++;
        if (seq !== 6'b00_01_01) begin fails++; $display("FAIL basic_sel_seq got=%b exp=000101", seq); end
        checks++;
        if (sent_cnt !== CNT_W'(3)) begin fails++; $display("FAIL basic_sent got=%0d exp=3", sent_cnt); end
    endtask

    task automatic test_miss();
        int bad;
        bad = 0;
        bit_valid = 1'b0;
        bit_data  = 1'($urandom_range(0, 1));
        for (int k = 0; k < PERIOD; k++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL miss_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (sel_out !== 2'b11 || pulse_out !== 2'b00) bad++;
            @(negedge clk);
            if (k == 0) bit_valid = 1'b1;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL miss_no_pulse got=%0d active cycles exp=0", bad); end
        checks++;
        if (miss_cnt !== CNT_W'(1)) begin fails++; $display("FAIL miss_cnt got=%0d exp=1", miss_cnt); end
        checks++;
        if (underflow !== 1'b1) begin fails++; $display("FAIL miss_underflow got=%b exp=1", underflow); end
        checks++;
        if (slot_start !== 1'b1) begin fails++; $display("FAIL miss_next_slot got=%b exp=1", slot_start); end
    endtask

    task automatic test_en_drop();
        int pulses, busy_fall, late_ready;
        pulses = 0; busy_fall = -1; late_ready = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL endrop_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (pulse_out != 2'b00) pulses++;
            if (busy_fall < 0 && !busy) busy_fall = i;
            if (i > 0 && bit_ready) late_ready++;
            if (m_pos == 0) bit_data = 1'($urandom_range(0, 1));
            if (i == 2) en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (pulses != PULSE_W) begin fails++; $display("FAIL endrop_pulse got=%0d exp=%0d", pulses, PULSE_W); end
        checks++;
        if (busy_fall != PERIOD) begin fails++; $display("FAIL endrop_busy_fall got=%0d exp=%0d", busy_fall, PERIOD); end
        checks++;
        if (late_ready != 0) begin fails++; $display("FAIL endrop_ready got=%0d exp=0", late_ready); end
    endtask

    task automatic test_rst_mid();
        logic [VW-1:0] rv;
        en = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        for (int g = 0; g < PERIOD && m_pos != 2; g++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL rstmid_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (m_pos == 0) bit_data = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (m_pos != 2 || pulse_out == 2'b00) begin
            fails++; $display("FAIL rstmid_pulse_before got=%b exp=nonzero", pulse_out);
        end
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rv = {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
        checks++;
        if (dut_v !== rv) begin fails++; $display("FAIL rstmid_values got=%h exp=%h", dut_v, rv); end
        @(negedge clk);
        checks++;
        if (dut_v !== exp_v() || busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle got=%h exp=%h", dut_v, exp_v());
        end
    endtask

    task automatic test_saturation();
        bit ok;
        en = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 * PERIOD; i++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL sat_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (m_pos == 0) bit_data = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (sent_cnt !== CNT_W'(CMAX)) begin fails++; $display("FAIL sat_sent got=%0d exp=%0d", sent_cnt, CMAX); end
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (sent_cnt !== '0) begin fails++; $display("FAIL sat_clr got=%0d exp=0", sent_cnt); end
        goto_fetch(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL sat_fetch1 timeout got=%0d exp=0", m_pos); end
        bit_valid = 1'b0;
        @(negedge clk);
        bit_valid = 1'b1;
        goto_fetch(ok);
        checks++;
        if (!ok || miss_cnt !== CNT_W'(1) || underflow !== 1'b1) begin
            fails++; $display("FAIL sat_miss got=%0d/%b exp=1/1", miss_cnt, underflow);
        end
        bit_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        bit_valid = 1'b1; clr = 1'b0;
        checks++;
        if (miss_cnt !== '0) begin fails++; $display("FAIL sat_clr_miss_cnt got=%0d exp=0", miss_cnt); end
        checks++;
        if (underflow !== 1'b1) begin fails++; $display("FAIL sat_clr_miss_uf got=%b exp=1", underflow); end
        checks++;
        if (dut_v !== exp_v()) begin fails++; $display("FAIL sat_clr_model got=%h exp=%h", dut_v, exp_v()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gaps [$];
        int run, ready_bad;
        bit seen;
        run = 0; ready_bad = 0; seen = 1'b0;
        goto_fetch(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL b2b_fetch timeout got=%0d exp=0", m_pos); end
        bit_data = 1'b1; bit_valid = 1'b1;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            checks++;
            if (dut_v !== exp_v()) begin
                fails++; $display("FAIL b2b_cycle t=%0t got=%h exp=%h", $time, dut_v, exp_v());
            end
            if (bit_ready !== (i % PERIOD == 0)) ready_bad++;
            if (pulse_out[1]) begin
                if (seen && run > 0) gaps.push_back(run);
                seen = 1'b1;
                run  = 0;
            end else if (seen) begin
                run++;
            end
            @(negedge clk);
        end
        checks++;
        if (gaps.size() != 3) begin fails++; $display("FAIL b2b_gap_count got=%0d exp=3", gaps.size()); end
        foreach (gaps[j]) begin
            checks++;
            if (gaps[j] != PERIOD - PULSE_W) begin
                fails++; $display("FAIL b2b_gap got=%0d exp=%0d", gaps[j], PERIOD - PULSE_W);
            end
        end
        checks++;
        if (ready_bad != 0) begin fails++; $display("FAIL b2b_ready got=%0d exp=0", ready_bad); end
        en = 1'b0;
        repeat (2 * PERIOD) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_stop got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miss();
        test_en_drop();
        test_rst_mid();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
